avalon_wait_ram: RTL and testbench

//  Avalon-MM slave memory that sits directly downstream of mips_cpu_bus and answers its

---
 rtl/avalon_wait_ram_if.sv | 24 ++
 rtl/avalon_wait_ram.sv | 209 ++++++++++++++++++++
 tb/tb_avalon_wait_ram.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM slave-side bus bundle between the CPU bus master and avalon_wait_ram.
interface avalon_wait_ram_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_wait_ram.sv
// Avalon-MM wait-state memory: instruction and data regions, N-cycle stall per transfer,
// sticky decode/protocol error flags. Define RANDOM_WAIT_EN to add 0..3 cycles of LFSR jitter.
module avalon_wait_ram #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] INSTR_BASE  = 32'hBFC0_0000,
    parameter int unsigned INSTR_AW    = 10,
    parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
    parameter int unsigned DATA_AW     = 12,
    parameter string       INIT_FILE   = ""
) (
    input  logic             clk,
    input  logic             reset,
    avalon_wait_ram_if.slave bus,
    output logic             bus_error,
    output logic             protocol_error
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned I_WORDS = 1 << INSTR_AW;
    localparam int unsigned D_WORDS = 1 << DATA_AW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rd;
        logic              wr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    xfer_t             snap_q, snap_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              berr_q, berr_d;
    logic              perr_q, perr_d;

    logic [DATA_W-1:0] imem [I_WORDS];
    logic [DATA_W-1:0] dmem [D_WORDS];

    xfer_t             live_c;
    logic [ADDR_W-1:0] cur_addr_c;
    logic              cur_rd_c;
    logic              cur_wr_c;
    logic [ADDR_W-1:0] i_off_c;
    logic [ADDR_W-1:0] d_off_c;
    logic              i_hit_c;
    logic              d_hit_c;
    logic [INSTR_AW-1:0] i_idx_c;
    logic [DATA_AW-1:0]  d_idx_c;
    logic              dec_err_c;
    logic [DATA_W-1:0] rd_word_c;
    logic              req_c;
    logic              done_c;
    logic              wait_c;
    logic              changed_c;
    logic [CNT_W-1:0]  first_cnt_c;
    logic              we_c;
    logic              we_i_c;
    logic              we_d_c;

    assign live_c = '{addr:  bus.address,
                      rd:    bus.read,
                      wr:    bus.write,
                      be:    bus.byteenable,
                      wdata: bus.writedata};

    // In WAIT the snapshot owns the transfer; in IDLE the live bus is the new request.
    assign cur_addr_c = (state_q == S_WAIT) ? snap_q.addr : live_c.addr;
    assign cur_rd_c   = (state_q == S_WAIT) ? snap_q.rd   : live_c.rd;
    assign cur_wr_c   = (state_q == S_WAIT) ? snap_q.wr   : live_c.wr;

    assign i_off_c   = cur_addr_c - INSTR_BASE;
    assign d_off_c   = cur_addr_c - DATA_BASE;
    assign i_hit_c   = (i_off_c >> (INSTR_AW + 2)) == '0;
    assign d_hit_c   = (d_off_c >> (DATA_AW + 2)) == '0;
    assign i_idx_c   = i_off_c[INSTR_AW+1:2];
    assign d_idx_c   = d_off_c[DATA_AW+1:2];
    assign dec_err_c = ~(i_hit_c | d_hit_c) | (cur_addr_c[1:0] != 2'b00) | (cur_rd_c & cur_wr_c);

    always_comb begin
        rd_word_c = '0;
        if (!dec_err_c) begin
            rd_word_c = i_hit_c ? imem[i_idx_c] : dmem[d_idx_c];
        end
    end

    assign req_c     = bus.read | bus.write;
    assign done_c    = (state_q == S_WAIT) && (cnt_q == '0);
    assign wait_c    = req_c & ~done_c;
    assign changed_c = (live_c != snap_q);

`ifdef RANDOM_WAIT_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per transfer start.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_IDLE && req_c) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign first_cnt_c = CNT_W'(WAIT_CYCLES - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign first_cnt_c = CNT_W'(WAIT_CYCLES - 1);
`endif

    // Transfer FSM: stall counter, snapshot, readdata and sticky flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        rdata_d = rdata_q;
        berr_d  = berr_q;
        perr_d  = perr_q;
        we_c    = 1'b0;

        if (wait_c) begin
            rdata_d = rd_word_c;
        end

        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    snap_d  = live_c;
                    cnt_d   = first_cnt_c;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    perr_d  = 1'b1;
                end else begin
                    if (changed_c) begin
                        perr_d = 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        we_c    = snap_q.wr & ~dec_err_c;
                        if (dec_err_c) begin
                            berr_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
            perr_q  <= perr_d;
        end
    end

    assign we_i_c = we_c & i_hit_c;
    assign we_d_c = we_c & ~i_hit_c & d_hit_c;

    // Byte-masked commit on the edge that ends the completion cycle; arrays are never cleared.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(BE_W); b++) begin
            if (we_i_c && snap_q.be[b]) begin
                imem[i_idx_c][8*b +: 8] <= snap_q.wdata[8*b +: 8];
            end
            if (we_d_c && snap_q.be[b]) begin
                dmem[d_idx_c][8*b +: 8] <= snap_q.wdata[8*b +: 8];
            end
        end
    end

    assign bus.waitrequest = wait_c;
    assign bus.readdata    = rdata_q;
    assign bus_error       = berr_q;
    assign protocol_error  = perr_q;
endmodule

// File: tb/tb_avalon_wait_ram.sv
// Randomized self-checking bench for avalon_wait_ram against an associative-array memory model.
`timescale 1ns/1ps
module tb_avalon_wait_ram;
`ifdef RANDOM_WAIT_EN
    localparam int N = 1;
`else
    localparam int N = 2;
`endif
    localparam logic [31:0] IBASE = 32'hBFC0_0000;
    localparam int          POOL  = 20;

    logic clk = 1'b0;
    logic reset;
    logic bus_error;
    logic protocol_error;

    avalon_wait_ram_if bus ();

    avalon_wait_ram #(
        .WAIT_CYCLES (N),
        .INSTR_BASE  (IBASE),
        .INSTR_AW    (10),
        .DATA_BASE   (32'h0000_0000),
        .DATA_AW     (12),
        .INIT_FILE   ("")
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .bus_error      (bus_error),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    logic [31:0] mdl [logic [31:0]];
    bit          m_berr;
    bit          m_perr;
    logic [31:0] pool [POOL];
    int          s1 [64];
    int          s2 [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] addr, input logic rd, input logic wr);
        bit hit;
        logic [1:0] lo;
        hit = (addr >= IBASE && addr < IBASE + 32'h1000) || (addr < 32'h4000);
        lo  = addr[1:0];
        return !hit || (lo != 2'b00) || (rd && wr);
    endfunction

    task automatic m_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] w;
        w = mdl.exists(addr) ? mdl[addr] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
        mdl[addr] = w;
    endtask

    task automatic check_stall(input string tag, input int stall);
`ifdef RANDOM_WAIT_EN
        chk(tag, 32'(stall >= N && stall <= N + 3), 32'd1);
`else
        chk(tag, 32'(stall), 32'(N));
`endif
    endtask

    // mode 0: hold inputs; 1: bump address after first stall cycle; 2: drop request after it
    task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [3:0] be, input logic [31:0] wd, input int mode,
                        output int stall, output logic [31:0] rdata);
        bit done;
        done  = 1'b0;
        stall = 0;
        rdata = 32'h0;
        @(negedge clk);
        bus.address    = addr;
        bus.read       = rd;
        bus.write      = wr;
        bus.byteenable = be;
        bus.writedata  = wd;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (bus.waitrequest) begin
                stall++;
                @(negedge clk);
                if (stall == 1 && mode == 1) bus.address = addr + 32'd4;
                if (stall == 1 && mode == 2) begin
                    bus.read  = 1'b0;
                    bus.write = 1'b0;
                    done      = 1'b1;
                end
            end else begin
                rdata = bus.readdata;
                done  = 1'b1;
            end
        end
        if (!done) chk("xfer_timeout", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        repeat (n - 1) @(negedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_bus_error"}, 32'(bus_error), 32'(m_berr));
        chk({tag, "_protocol_error"}, 32'(protocol_error), 32'(m_perr));
    endtask

    task automatic do_op(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] wd, input int gap);
        int          stall;
        logic [31:0] rdata;
        logic [31:0] exp_rd;
        bit          err;
        err    = m_err(addr, rd, wr);
        exp_rd = (err || !mdl.exists(addr)) ? 32'h0 : mdl[addr];
        xfer(addr, rd, wr, be, wd, 0, stall, rdata);
        check_stall($sformatf("stall@%h", addr), stall);
        if (rd) chk($sformatf("rdata@%h", addr), rdata, exp_rd);
        if (err) m_berr = 1'b1;
        else if (wr) m_write(addr, be, wd);
        if (gap > 0) begin
            idle(gap);
            check_flags("op");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        m_berr    = 1'b0;
        m_perr    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef RANDOM_WAIT_EN
    task automatic seq_run(input bit second);
        int          st;
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            xfer(32'h10, 1'b1, 1'b0, 4'hF, 32'h0, 0, st, rd);
            check_stall("seq_stall", st);
            if (second) s2[i] = st;
            else        s1[i] = st;
            idle(1);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          stall;
        int          k;
        int          p;
        int          gap;
        logic [31:0] rdata;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd;
        logic        wr;

        reset          = 1'b1;
        bus.address    = 32'h0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.byteenable = 4'h0;
        bus.writedata  = 32'h0;
        m_berr         = 1'b0;
        m_perr         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_readdata", bus.readdata, 32'h0);
        check_flags("reset");
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_waitrequest", 32'(bus.waitrequest), 32'd0);

        // Reset-vector word, then byte-lane merge
        do_op(IBASE, 1'b0, 1'b1, 4'hF, 32'h3C02_0001, 1);
        do_op(IBASE, 1'b1, 1'b0, 4'h0, 32'h0, 1);
        do_op(32'h10, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF, 1);
        do_op(32'h10, 1'b0, 1'b1, 4'b0010, 32'h0000_5500, 0);
        do_op(32'h10, 1'b1, 1'b0, 4'hF, 32'h0, 1);
        chk("merge_model", mdl[32'h10], 32'hDEAD_55EF);
        do_op(32'h10, 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF, 1);
        do_op(32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 1);

        // Region boundaries, last valid words
        do_op(32'h3FFC, 1'b0, 1'b1, 4'hF, 32'h1234_5678, 1);
        do_op(32'h3FFC, 1'b1, 1'b0, 4'hF, 32'h0, 1);
        do_op(IBASE + 32'hFFC, 1'b0, 1'b1, 4'hF, 32'h8765_4321, 1);
        do_op(IBASE + 32'hFFC, 1'b1, 1'b0, 4'hF, 32'h0, 1);

        for (int i = 0; i < POOL; i++) begin
            pool[i] = (i < 16) ? 32'h100 + 32'(4 * i) : IBASE + 32'h40 + 32'(4 * (i - 16));
            do_op(pool[i], 1'b0, 1'b1, 4'hF, $urandom, 0);
        end
        do_op(32'h14, 1'b0, 1'b1, 4'hF, 32'h1414_1414, 0);
        do_op(32'h18, 1'b0, 1'b1, 4'hF, 32'h1818_1818, 0);
        do_op(32'h20, 1'b0, 1'b1, 4'hF, 32'h1111_1111, 1);

        // Decode errors: misaligned, unmapped and just outside each region
        do_op(32'h12, 1'b1, 1'b0, 4'hF, 32'h0, 1);
        do_op(32'h8000_0000, 1'b1, 1'b0, 4'hF, 32'h0, 1);
        do_op(32'h10, 1'b1, 1'b0, 4'hF, 32'h0, 1);
        do_op(32'h4000, 1'b1, 1'b0, 4'hF, 32'h0, 1);
        do_op(IBASE + 32'h1000, 1'b1, 1'b0, 4'hF, 32'h0, 1);
        do_op(IBASE - 32'd4, 1'b0, 1'b1, 4'hF, 32'hBAD0_BAD0, 1);
        do_op(32'h20, 1'b1, 1'b1, 4'hF, 32'hBAD1_BAD1, 1);

        // Reset during first cycle of a write, request dropped before release
        @(negedge clk);
        bus.address = 32'h20; bus.write = 1'b1; bus.read = 1'b0;
        bus.byteenable = 4'hF; bus.writedata = 32'hCAFE_F00D;
        #1;
        reset = 1'b1; m_berr = 1'b0; m_perr = 1'b0;
        @(negedge clk);
        bus.write = 1'b0;
        #1;
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_waitrequest", 32'(bus.waitrequest), 32'd0);
        check_flags("rst");
        @(negedge clk);
        reset = 1'b0;
        do_op(32'h20, 1'b1, 1'b0, 4'hF, 32'h0, 1);

        // Reset mid-write with request held: fresh N-cycle transfer after release
        @(negedge clk);
        bus.address = 32'h20; bus.write = 1'b1; bus.read = 1'b0;
        bus.byteenable = 4'hF; bus.writedata = 32'hCAFE_F00D;
        #1;
        reset = 1'b1; m_berr = 1'b0; m_perr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        xfer(32'h20, 1'b0, 1'b1, 4'hF, 32'hCAFE_F00D, 0, stall, rdata);
        check_stall("rst_resume_stall", stall);
        m_write(32'h20, 4'hF, 32'hCAFE_F00D);
        idle(1);
        check_flags("rst_resume");
        do_op(32'h20, 1'b1, 1'b0, 4'hF, 32'h0, 1);

        // Protocol violations: address moved mid-transfer, then request dropped
        xfer(32'h10, 1'b1, 1'b0, 4'hF, 32'h0, 1, stall, rdata);
        check_stall("addr_change_stall", stall);
        chk("addr_change_rdata", rdata, mdl[32'h10]);
        m_perr = 1'b1;
        idle(1);
        check_flags("addr_change");
        xfer(32'h18, 1'b0, 1'b1, 4'hF, 32'hA5A5_A5A5, 2, stall, rdata);
        idle(1);
        check_flags("abort");
        do_op(32'h18, 1'b1, 1'b0, 4'hF, 32'h0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            k  = $urandom_range(0, 9);
            p  = $urandom_range(0, POOL - 1);
            a  = pool[p];
            rd = 1'($urandom_range(0, 1));
            wr = ~rd;
            be = 4'($urandom);
            wd = $urandom;
            case (k)
                0: begin a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC); rd = 1'b1; wr = 1'b0; end
                1: a = a + 32'($urandom_range(1, 3));
                2: begin rd = 1'b1; wr = 1'b1; end
                default: ;
            endcase
            gap = $urandom_range(0, 2);
            do_op(a, rd, wr, be, wd, gap);
        end
        idle(1);
        check_flags("random_end");

`ifdef RANDOM_WAIT_EN
        seq_run(1'b0);
        seq_run(1'b1);
        begin
            bit seen [8];
            int distinct;
            distinct = 0;
            for (int i = 0; i < 8; i++) seen[i] = 1'b0;
            for (int i = 0; i < 64; i++) begin
                chk($sformatf("seq_repeat[%0d]", i), 32'(s2[i]), 32'(s1[i]));
                if (s1[i] >= 0 && s1[i] < 8 && !seen[s1[i]]) begin
                    seen[s1[i]] = 1'b1;
                    distinct++;
                end
            end
            chk("seq_distinct", 32'(distinct >= 2), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
